// File: rtl/serial_add_sched_pkg.sv
// Shared definitions for the bit-serial add scheduler: FSM encoding, requester count,
// and the bit-counter width helper.
package serial_add_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int NREQ = 2;

    // Counter must be able to hold the value WIDTH.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/halfadder.sv
// Gate-level half adder cell.
module halfadder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

// File: rtl/serial_fa_bit.sv
// Combinational 1-bit full adder assembled from two half adder cells.
module serial_fa_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);
    logic s1;
    logic c1;
    logic c2;

    halfadder u_ha0 (.a(a),  .b(b),   .s(s1), .c(c1));
    halfadder u_ha1 (.a(s1), .b(cin), .s(s),  .c(c2));

    assign co = c1 | c2;
endmodule

// File: rtl/serial_add_sched.sv
// Round-robin scheduler sharing one bit-serial full adder between two requesters.
// Define SERIAL_ADD_SUB_EN to add sub0/sub1 ports for a - b mode.
module serial_add_sched
    import serial_add_sched_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub0,
    input  logic             sub1,
`endif
    output logic [NREQ-1:0]  gnt,
    output logic             busy,
    output logic [NREQ-1:0]  done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = cnt_width(WIDTH);

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res_reg;
    logic             carry_reg;
    logic [CW-1:0]    cnt_reg;
    logic             prio_reg;
    logic [NREQ-1:0]  gnt_reg;
    logic             busy_reg;
    logic [NREQ-1:0]  done_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;

    logic [WIDTH-1:0] a_req [NREQ];
    logic [WIDTH-1:0] b_req [NREQ];
    logic [NREQ-1:0]  sub_req;
    logic             sel;
    logic [NREQ-1:0]  arb_gnt;
    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] res_next;

    assign a_req[0] = a0;
    assign a_req[1] = a1;
    assign b_req[0] = b0;
    assign b_req[1] = b1;
`ifdef SERIAL_ADD_SUB_EN
    assign sub_req = {sub1, sub0};
`else
    assign sub_req = '0;
`endif

    assign sel = gnt_reg[1];

    // prio_reg names the requester that wins a tie.
    always_comb begin
        arb_gnt = req;
        if (req[0] && req[1])
            arb_gnt = prio_reg ? 2'b10 : 2'b01;
    end

    serial_fa_bit u_fa (
        .a  (a_reg[0]),
        .b  (b_reg[0]),
        .cin(carry_reg),
        .s  (fa_s),
        .co (fa_co)
    );

    assign res_next = (res_reg >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            prio_reg  <= 1'b0;
            gnt_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= '0;
                    if (|req) begin
                        gnt_reg   <= arb_gnt;
                        busy_reg  <= 1'b1;
                        state_reg <= LOAD;
                    end
                end
                LOAD: begin
                    a_reg     <= a_req[sel];
                    b_reg     <= sub_req[sel] ? ~b_req[sel] : b_req[sel];
                    carry_reg <= sub_req[sel];
                    cnt_reg   <= '0;
                    state_reg <= SHIFT;
                end
                SHIFT: begin
                    a_reg     <= a_reg >> 1;
                    b_reg     <= b_reg >> 1;
                    res_reg   <= res_next;
                    carry_reg <= fa_co;
                    cnt_reg   <= cnt_reg + 1'b1;
                    // Publish on the last step so results are visible during DONE.
                    if (cnt_reg == CW'(WIDTH - 1)) begin
                        sum_reg   <= res_next;
                        cout_reg  <= fa_co;
                        done_reg  <= gnt_reg;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    done_reg  <= '0;
                    gnt_reg   <= '0;
                    busy_reg  <= 1'b0;
                    prio_reg  <= gnt_reg[0];
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign gnt  = gnt_reg;
    assign busy = busy_reg;
    assign done = done_reg;
    assign sum  = sum_reg;
    assign cout = cout_reg;

endmodule

// File: tb/tb_serial_add_sched.sv
// Scoreboard bench for serial_add_sched (WIDTH=8); sub-mode vectors run when
// SERIAL_ADD_SUB_EN is defined.
module tb_serial_add_sched;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   req = '0;
    logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
`ifdef SERIAL_ADD_SUB_EN
    logic         sub0 = 1'b0, sub1 = 1'b0;
`endif
    logic [1:0]   gnt;
    logic         busy;
    logic [1:0]   done;
    logic [W-1:0] sum;
    logic         cout;

    serial_add_sched #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (req),
        .a0   (a0),
        .b0   (b0),
        .a1   (a1),
        .b1   (b1),
`ifdef SERIAL_ADD_SUB_EN
        .sub0 (sub0),
        .sub1 (sub1),
`endif
        .gnt  (gnt),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   d;
        logic [W-1:0] s;
        logic         c;
        int           at;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done != 2'b00) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done=%b expected none (cycle %0d)", done, cyc);
            end else begin
                e = q.pop_front();
                chk("done_vec", 32'(done), 32'(e.d));
                chk("sum", 32'(sum), 32'(e.s));
                chk("cout", 32'(cout), 32'(e.c));
                chk("done_cycle", cyc, e.at);
                $display("done=%b sum=%02h cout=%b at cycle %0d", done, sum, cout, cyc);
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] es, input logic ec, input int lat);
        if (id == 0) begin a0 = a; b0 = b; end
        else begin a1 = a; b1 = b; end
        req[id] = 1'b1;
        q.push_back('{d: 2'(1 << id), s: es, c: ec, at: cyc + lat});
    endtask

    task automatic run_single(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] es, input logic ec);
        issue(id, a, b, es, ec, W + 2);
        wait_cycles(1);
        chk("gnt_load", 32'(gnt), 32'(1 << id));
        chk("busy_load", 32'(busy), 1);
        wait_cycles(W + 1);
        req[id] = 1'b0;
        wait_cycles(1);
        chk("gnt_idle", 32'(gnt), 0);
        chk("busy_idle", 32'(busy), 0);
    endtask

    initial begin
        #200000;
        n_err++;
        $display("FAIL timeout: got no finish expected finish within 200000 time units");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        int k;
        wait_cycles(3);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_sum", 32'(sum), 0);
        chk("rst_cout", 32'(cout), 0);
        rst_n = 1'b1;
        wait_cycles(2);

        run_single(0, 8'h5A, 8'h3C, 8'h96, 1'b0);
        run_single(1, 8'hFF, 8'h01, 8'h00, 1'b1);
        run_single(1, 8'hFF, 8'hFF, 8'hFE, 1'b1);

        // Fresh reset, then both requesters held: 0, 1, 0 in order.
        rst_n = 1'b0;
        wait_cycles(1);
        rst_n = 1'b1;
        wait_cycles(1);
        k = cyc;
        issue(0, 8'h12, 8'h34, 8'h46, 1'b0, W + 2);
        issue(1, 8'hC8, 8'h64, 8'h2C, 1'b1, 2 * (W + 3) - 1);
        q.push_back('{d: 2'b01, s: 8'h46, c: 1'b0, at: k + 3 * (W + 3) - 1});
        wait_cycles(1);
        chk("rr_gnt_first", 32'(gnt), 32'b01);
        wait_cycles(W + 3);
        chk("rr_gnt_second", 32'(gnt), 32'b10);
        wait_cycles(W + 3);
        chk("rr_gnt_third", 32'(gnt), 32'b01);
        wait_cycles(W + 1);
        req = 2'b00;
        wait_cycles(2);
        chk("rr_idle_gnt", 32'(gnt), 0);

        // Reset during SHIFT cycle 5 aborts with no done pulse.
        a0 = 8'h11; b0 = 8'h22; req[0] = 1'b1;
        wait_cycles(5);
        rst_n = 1'b0;
        #1;
        chk("abort_gnt", 32'(gnt), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_sum", 32'(sum), 0);
        chk("abort_cout", 32'(cout), 0);
        req = 2'b00;
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(1);
        run_single(0, 8'h80, 8'h80, 8'h00, 1'b1);
        run_single(1, 8'h7F, 8'h01, 8'h80, 1'b0);

        // Requester drops req in SHIFT; the operation still completes.
        issue(0, 8'h33, 8'h44, 8'h77, 1'b0, W + 2);
        wait_cycles(4);
        req[0] = 1'b0;
        wait_cycles(1);
        chk("drop_gnt_held", 32'(gnt), 32'b01);
        wait_cycles(W);

`ifdef SERIAL_ADD_SUB_EN
        sub0 = 1'b1;
        run_single(0, 8'h10, 8'h01, 8'h0F, 1'b1);
        run_single(0, 8'h01, 8'h02, 8'hFF, 1'b0);
        sub0 = 1'b0;
`endif

        wait_cycles(3);
        chk("pending_expectations", 32'(q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/serial_add_sched.md
# serial_add_sched

Scheduler that shares one bit-serial 1-bit full-adder datapath between two requesters in the processor's arithmetic section. It arbitrates round-robin, captures the winner's operands, steps the adder LSB-first over WIDTH cycles with a registered carry, and returns a WIDTH-bit sum plus carry-out with a one-cycle done pulse. It sits between instruction-execution units and the gate-level adder cells, so several units can use one small adder.

## Interface
- WIDTH, 8: operand/result width in bits; legal range is 1..32.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  2  request per requester; bit i is requester i.
- a0, b0  in  WIDTH  operands of requester 0.
- a1, b1  in  WIDTH  operands of requester 1.
- gnt  out  2  one-hot grant, registered; held from LOAD through DONE.
- busy  out  1  high in LOAD, SHIFT and DONE.
- done  out  2  one-cycle pulse to the granted requester in DONE.
- sum  out  WIDTH  result, registered; holds its value until the next DONE.
- cout  out  1  carry out of the MSB; holds like sum.

## Operation
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE, with any req high:
  - Grant one requester. If both are high, the requester not granted last wins.
  - The priority pointer resets to favour requester 0.
  - Go to LOAD.
- LOAD:
  - Copy the granted operands into shift registers A and B.
  - Clear the carry flip-flop (or preset it; see Configuration).
  - Clear the bit counter and go to SHIFT.
- SHIFT, each cycle:
  - Drive the adder with A[0], B[0] and carry.
  - Shift the sum bit into the MSB of the result shift register.
  - Register the adder carry.
  - Shift A and B right and increment the counter.
  - After WIDTH cycles, go to DONE.
- DONE:
  - Transfer the result register to sum and the final carry to cout.
  - Pulse done[granted].
  - Update the priority pointer, clear gnt, return to IDLE.
- Arithmetic: sum = (a + b) mod 2^WIDTH; cout = bit WIDTH of the full sum.
- Requester protocol: hold req and operands stable until done. Operands are sampled only in LOAD.
- If req drops mid-operation, the operation still completes and done still pulses. The result goes unclaimed.
- A req that rises during LOAD, SHIFT or DONE is not seen until IDLE.
- Each requester holds at most one outstanding operation.

## Timing
- Reset values: gnt=0, busy=0, done=0, sum=0, cout=0; state=IDLE; pointer favours requester 0.
- Reset is asynchronous. Asserting it mid-operation aborts immediately: no done pulse, and sum/cout clear.
- Cycle numbering from the IDLE cycle in which req is seen (cycle 0):
  - LOAD at cycle 1; gnt and busy become visible here.
  - SHIFT at cycles 2..WIDTH+1.
  - DONE at cycle WIDTH+2; done, sum and cout update here.
  - IDLE at cycle WIDTH+3.
- Latency is WIDTH+2 cycles from req-seen to done.
- Issue interval is WIDTH+3 cycles: a pending request is granted in the IDLE cycle right after DONE.
- WIDTH=1: exactly one SHIFT cycle.

## Configuration
- SERIAL_ADD_SUB_EN defined:
  - Adds input ports sub0 and sub1 (1 bit each), sampled in LOAD.
  - When sub is set, B is loaded inverted and carry is preset to 1, so sum = a - b mod 2^WIDTH.
  - cout=1 means no borrow.
- SERIAL_ADD_SUB_EN undefined: the sub ports are absent, and the block only adds, with carry cleared in LOAD.

## Structure
- Shared package holds:
  - state encodings IDLE=2'd0, LOAD=2'd1, SHIFT=2'd2, DONE=2'd3;
  - the requester count constant NREQ=2;
  - the counter-width function (clog2 of WIDTH+1).
- One sub-module, serial_fa_bit: a combinational 1-bit full adder built from two existing halfadder instances, with the two carries ORed. It is instantiated once inside the scheduler.
- The carry flip-flop, shift registers, counter, arbiter and FSM stay in serial_add_sched.

## Test plan
- WIDTH=8, req=01, a0=0x5A, b0=0x3C -> done[0] at cycle 10; sum=0x96, cout=0; gnt returns to 0 at cycle 11.
- req=10, a1=0xFF, b1=0x01 -> sum=0x00, cout=1, done[1] only.
- After reset, req=11 held continuously -> requester 0 served first (done[0] at cycle 10), then requester 1 granted at cycle 11 (done[1] at cycle 21), then requester 0 again.
- rst_n low during SHIFT cycle 5 -> gnt, busy, done, sum and cout all 0 at once; no done pulse; a fresh req after release completes normally.
- req[0] dropped in SHIFT -> done[0] still pulses at cycle 10 with the correct sum.
- With SERIAL_ADD_SUB_EN: sub0=1, a0=0x10, b0=0x01 -> sum=0x0F, cout=1. Then a0=0x01, b0=0x02 -> sum=0xFF, cout=0.
